// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one memory port between instruction fetch (I)
// and data load/store (D). Data wins by default. A starvation counter lets
// fetch win after STARVE_MAX consecutive denials. A tag pipe of MEM_LAT
// stages routes each read response back to the requester that issued it.
module mem_port_arbiter #(
    parameter int unsigned AW         = 16,
    parameter int unsigned DW         = 16,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    // fetch requester
    input  logic          if_req_valid,
    output logic          if_req_ready,
    input  logic [AW-1:0] if_req_addr,
    output logic          if_rsp_valid,
    output logic [DW-1:0] if_rsp_data,
    // data requester
    input  logic          d_req_valid,
    output logic          d_req_ready,
    input  logic          d_req_we,
    input  logic [AW-1:0] d_req_addr,
    input  logic [DW-1:0] d_req_wdata,
    output logic          d_rsp_valid,
    output logic [DW-1:0] d_rsp_data,
    // memory side
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [SW-1:0]      starve_cnt_q, starve_cnt_d;
    logic               starved;
    logic               gnt_i, gnt_d;
    logic               rd_issue;
    logic [MEM_LAT-1:0] tag_vld_q;
    logic [MEM_LAT-1:0] tag_own_q;  // 1 = data requester, 0 = fetch

    // Grant decision: data first unless fetch has been denied long enough.
    always_comb begin
        starved = (starve_cnt_q == SW'(STARVE_MAX));
        gnt_i   = if_req_valid & (~d_req_valid | starved);
        gnt_d   = d_req_valid & ~gnt_i;
    end

    // Request forwarding; memory strobes are held off while reset is asserted.
    always_comb begin
        if_req_ready = gnt_i;
        d_req_ready  = gnt_d;
        mem_en       = rst_n & (gnt_i | gnt_d);
        mem_we       = rst_n & gnt_d & d_req_we;
        mem_addr     = '0;
        mem_wdata    = '0;
        if (gnt_d) begin
            mem_addr  = d_req_addr;
            mem_wdata = d_req_wdata;
        end else if (gnt_i) begin
            mem_addr  = if_req_addr;
        end
        rd_issue     = mem_en & ~mem_we;
    end

    // Starvation counter next state: count fetch denials, saturate, clear on
    // grant or when fetch stops asking.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!if_req_valid || gnt_i) begin
            starve_cnt_d = '0;
        end else if (!starved) begin
            starve_cnt_d = starve_cnt_q + SW'(1);
        end
    end

    // State: starvation counter and response tag pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
            tag_vld_q    <= '0;
            tag_own_q    <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            tag_vld_q[0] <= rd_issue;
            tag_own_q[0] <= gnt_d;
            for (int i = 1; i < MEM_LAT; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_own_q[i] <= tag_own_q[i-1];
            end
        end
    end

    // Response routing from the last tag stage.
    always_comb begin
        if_rsp_valid = tag_vld_q[MEM_LAT-1] & ~tag_own_q[MEM_LAT-1];
        d_rsp_valid  = tag_vld_q[MEM_LAT-1] &  tag_own_q[MEM_LAT-1];
        if_rsp_data  = mem_rdata;
        d_rsp_data   = mem_rdata;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Two instances share the request
// inputs: dut_a with MEM_LAT=1 and dut_b with MEM_LAT=2, each with its own
// behavioural memory.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_valid;
    logic [15:0] if_req_addr;
    logic        d_req_valid;
    logic        d_req_we;
    logic [15:0] d_req_addr;
    logic [15:0] d_req_wdata;

    logic        a_if_req_ready, a_if_rsp_valid, a_d_req_ready, a_d_rsp_valid;
    logic [15:0] a_if_rsp_data, a_d_rsp_data;
    logic        a_mem_en, a_mem_we;
    logic [15:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

    logic        b_if_req_ready, b_if_rsp_valid, b_d_req_ready, b_d_rsp_valid;
    logic [15:0] b_if_rsp_data, b_d_rsp_data;
    logic        b_mem_en, b_mem_we;
    logic [15:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [15:0] b_rd_stage;

    logic [15:0] a_mem [0:65535];
    logic [15:0] b_mem [0:65535];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(1), .STARVE_MAX(4)) dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_req_valid (if_req_valid),
        .if_req_ready (a_if_req_ready),
        .if_req_addr  (if_req_addr),
        .if_rsp_valid (a_if_rsp_valid),
        .if_rsp_data  (a_if_rsp_data),
        .d_req_valid  (d_req_valid),
        .d_req_ready  (a_d_req_ready),
        .d_req_we     (d_req_we),
        .d_req_addr   (d_req_addr),
        .d_req_wdata  (d_req_wdata),
        .d_rsp_valid  (a_d_rsp_valid),
        .d_rsp_data   (a_d_rsp_data),
        .mem_en       (a_mem_en),
        .mem_we       (a_mem_we),
        .mem_addr     (a_mem_addr),
        .mem_wdata    (a_mem_wdata),
        .mem_rdata    (a_mem_rdata)
    );

    mem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(2), .STARVE_MAX(4)) dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_req_valid (if_req_valid),
        .if_req_ready (b_if_req_ready),
        .if_req_addr  (if_req_addr),
        .if_rsp_valid (b_if_rsp_valid),
        .if_rsp_data  (b_if_rsp_data),
        .d_req_valid  (d_req_valid),
        .d_req_ready  (b_d_req_ready),
        .d_req_we     (d_req_we),
        .d_req_addr   (d_req_addr),
        .d_req_wdata  (d_req_wdata),
        .d_rsp_valid  (b_d_rsp_valid),
        .d_rsp_data   (b_d_rsp_data),
        .mem_en       (b_mem_en),
        .mem_we       (b_mem_we),
        .mem_addr     (b_mem_addr),
        .mem_wdata    (b_mem_wdata),
        .mem_rdata    (b_mem_rdata)
    );

    // One-cycle latency memory for dut_a.
    always @(posedge clk) begin
        if (a_mem_en && a_mem_we) a_mem[a_mem_addr] <= a_mem_wdata;
        if (a_mem_en && !a_mem_we) a_mem_rdata <= a_mem[a_mem_addr];
    end

    // Two-cycle latency memory for dut_b.
    always @(posedge clk) begin
        if (b_mem_en && b_mem_we) b_mem[b_mem_addr] <= b_mem_wdata;
        if (b_mem_en && !b_mem_we) b_rd_stage <= b_mem[b_mem_addr];
        b_mem_rdata <= b_rd_stage;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req_valid = 1'b0;
        if_req_addr  = 16'h0;
        d_req_valid  = 1'b0;
        d_req_we     = 1'b0;
        d_req_addr   = 16'h0;
        d_req_wdata  = 16'h0;
    endtask

    initial begin
        a_mem[16'h0010] = 16'h1234;
        a_mem[16'h0100] = 16'h5678;
        for (int i = 0; i < 6; i++) b_mem[16'h0300 + 16'(i)] = 16'hA000 + 16'(i);

        rst_n = 1'b0;
        idle_inputs();
        #1;
        check_eq("reset_a_if_rsp_valid", 32'(a_if_rsp_valid), 32'd0);
        check_eq("reset_a_d_rsp_valid", 32'(a_d_rsp_valid), 32'd0);
        check_eq("reset_a_mem_en", 32'(a_mem_en), 32'd0);
        next_cycle();
        rst_n = 1'b1;

        // Fetch alone, MEM_LAT=1
        if_req_valid = 1'b1;
        if_req_addr  = 16'h0010;
        #1;
        check_eq("t1_if_ready", 32'(a_if_req_ready), 32'd1);
        check_eq("t1_d_ready", 32'(a_d_req_ready), 32'd0);
        check_eq("t1_mem_en", 32'(a_mem_en), 32'd1);
        check_eq("t1_mem_we", 32'(a_mem_we), 32'd0);
        check_eq("t1_mem_addr", 32'(a_mem_addr), 32'h0010);
        next_cycle();
        idle_inputs();
        #1;
        check_eq("t1_if_rsp_valid", 32'(a_if_rsp_valid), 32'd1);
        check_eq("t1_if_rsp_data", 32'(a_if_rsp_data), 32'h1234);
        check_eq("t1_d_rsp_valid", 32'(a_d_rsp_valid), 32'd0);
        next_cycle();

        // Simultaneous requests, data wins
        if_req_valid = 1'b1;
        if_req_addr  = 16'h0010;
        d_req_valid  = 1'b1;
        d_req_addr   = 16'h0100;
        #1;
        check_eq("t2_d_ready", 32'(a_d_req_ready), 32'd1);
        check_eq("t2_if_ready", 32'(a_if_req_ready), 32'd0);
        check_eq("t2_mem_addr", 32'(a_mem_addr), 32'h0100);
        next_cycle();
        idle_inputs();
        #1;
        check_eq("t2_d_rsp_valid", 32'(a_d_rsp_valid), 32'd1);
        check_eq("t2_d_rsp_data", 32'(a_d_rsp_data), 32'h5678);
        check_eq("t2_if_rsp_valid", 32'(a_if_rsp_valid), 32'd0);
        check_eq("idle_mem_en", 32'(a_mem_en), 32'd0);
        check_eq("idle_mem_addr", 32'(a_mem_addr), 32'd0);
        check_eq("idle_mem_wdata", 32'(a_mem_wdata), 32'd0);
        next_cycle();

        // Starvation: fetch held until accepted, data held 10 cycles
        for (int k = 1; k <= 11; k++) begin
            d_req_valid  = 1'b1;
            d_req_addr   = 16'h0100;
            if_req_valid = (k <= 5) || (k == 11);
            if_req_addr  = 16'h0010;
            #1;
            check_eq($sformatf("t3_if_ready_c%0d", k), 32'(a_if_req_ready), 32'(k == 5));
            check_eq($sformatf("t3_d_ready_c%0d", k), 32'(a_d_req_ready), 32'(k != 5));
            check_eq($sformatf("t3_mem_addr_c%0d", k), 32'(a_mem_addr),
                     (k == 5) ? 32'h0010 : 32'h0100);
            if (k >= 2) begin
                check_eq($sformatf("t3_if_rsp_c%0d", k), 32'(a_if_rsp_valid), 32'(k == 6));
                check_eq($sformatf("t3_d_rsp_c%0d", k), 32'(a_d_rsp_valid), 32'(k != 6));
            end
            if (k == 6) check_eq("t3_if_rsp_data", 32'(a_if_rsp_data), 32'h1234);
            next_cycle();
        end
        idle_inputs();
        next_cycle();

        // Write then read back
        d_req_valid = 1'b1;
        d_req_we    = 1'b1;
        d_req_addr  = 16'h0200;
        d_req_wdata = 16'hBEEF;
        #1;
        check_eq("t4_wr_ready", 32'(a_d_req_ready), 32'd1);
        check_eq("t4_wr_mem_we", 32'(a_mem_we), 32'd1);
        check_eq("t4_wr_mem_addr", 32'(a_mem_addr), 32'h0200);
        check_eq("t4_wr_mem_wdata", 32'(a_mem_wdata), 32'hBEEF);
        next_cycle();
        d_req_we    = 1'b0;
        d_req_wdata = 16'h0;
        #1;
        check_eq("t4_rd_mem_we", 32'(a_mem_we), 32'd0);
        check_eq("t4_no_wr_rsp", 32'(a_d_rsp_valid), 32'd0);
        next_cycle();
        idle_inputs();
        #1;
        check_eq("t4_rd_rsp_valid", 32'(a_d_rsp_valid), 32'd1);
        check_eq("t4_rd_rsp_data", 32'(a_d_rsp_data), 32'hBEEF);
        next_cycle();
        next_cycle();

        // MEM_LAT=2, alternating fetch/data reads
        for (int k = 0; k < 8; k++) begin
            idle_inputs();
            if (k < 6) begin
                if (k % 2 == 0) begin
                    if_req_valid = 1'b1;
                    if_req_addr  = 16'h0300 + 16'(k);
                end else begin
                    d_req_valid = 1'b1;
                    d_req_addr  = 16'h0300 + 16'(k);
                end
            end
            #1;
            if (k < 6) begin
                check_eq($sformatf("t5_mem_en_c%0d", k), 32'(b_mem_en), 32'd1);
                check_eq($sformatf("t5_mem_addr_c%0d", k), 32'(b_mem_addr), 32'h0300 + 32'(k));
            end
            if (k >= 2) begin
                check_eq($sformatf("t5_if_rsp_c%0d", k), 32'(b_if_rsp_valid), 32'(k % 2 == 0));
                check_eq($sformatf("t5_d_rsp_c%0d", k), 32'(b_d_rsp_valid), 32'(k % 2 == 1));
                if (k % 2 == 0)
                    check_eq($sformatf("t5_if_data_c%0d", k), 32'(b_if_rsp_data),
                             32'hA000 + 32'(k - 2));
                else
                    check_eq($sformatf("t5_d_data_c%0d", k), 32'(b_d_rsp_data),
                             32'hA000 + 32'(k - 2));
            end else begin
                check_eq($sformatf("t5_no_rsp_c%0d", k), 32'(b_if_rsp_valid | b_d_rsp_valid), 32'd0);
            end
            next_cycle();
        end

        // Reset with reads in flight and a partly starved fetch, MEM_LAT=2
        for (int s = 1; s <= 4; s++) begin
            if_req_valid = 1'b1;
            if_req_addr  = 16'h0300;
            d_req_valid  = 1'b1;
            d_req_addr   = 16'h0301;
            #1;
            check_eq($sformatf("t6_pre_d_ready_c%0d", s), 32'(b_d_req_ready), 32'd1);
            if (s < 4) next_cycle();
        end
        check_eq("t6_pre_rsp_valid", 32'(b_d_rsp_valid), 32'd1);
        check_eq("t6_pre_rsp_data", 32'(b_d_rsp_data), 32'hA001);
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_if_rsp", 32'(b_if_rsp_valid), 32'd0);
        check_eq("t6_rst_d_rsp", 32'(b_d_rsp_valid), 32'd0);
        check_eq("t6_rst_mem_en", 32'(b_mem_en), 32'd0);
        check_eq("t6_rst_mem_we", 32'(b_mem_we), 32'd0);
        check_eq("t6_rst_d_ready", 32'(b_d_req_ready), 32'd1);
        next_cycle();
        rst_n = 1'b1;
        for (int p = 1; p <= 5; p++) begin
            #1;
            check_eq($sformatf("t6_post_d_ready_c%0d", p), 32'(b_d_req_ready), 32'(p < 5));
            check_eq($sformatf("t6_post_if_ready_c%0d", p), 32'(b_if_req_ready), 32'(p == 5));
            if (p <= 2)
                check_eq($sformatf("t6_dropped_rsp_c%0d", p),
                         32'(b_if_rsp_valid | b_d_rsp_valid), 32'd0);
            if (p == 3) begin
                check_eq("t6_first_rsp_valid", 32'(b_d_rsp_valid), 32'd1);
                check_eq("t6_first_rsp_data", 32'(b_d_rsp_data), 32'hA001);
                check_eq("t6_first_if_rsp", 32'(b_if_rsp_valid), 32'd0);
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
